// File: rtl/tdm_demux4.sv
`default_nettype none
// ============================================================================
// Module      : tdm_demux4
// Description : Receive end of a 4-slot TDM link. Locks onto a frame-sync
//               pulse, tracks the slot number, gathers one W-bit sample per
//               slot into shadow registers and publishes complete frames on
//               a/b/c/d together with a one-cycle frame_valid pulse. Framing
//               violations produce a one-cycle sync_err pulse.
//               Optional feature macro: TDM_ERR_CNT_EN (adds saturating
//               8-bit err_cnt output counting sync_err pulses).
// Revision    : 1.0 - initial release
// ============================================================================
module tdm_demux4 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         sync,
  input  logic [W-1:0] din,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  output logic [W-1:0] c,
  output logic [W-1:0] d,
  output logic [1:0]   S,
`ifdef TDM_ERR_CNT_EN
  output logic [7:0]   err_cnt,
`endif
  output logic         frame_valid,
  output logic         sync_err
);

  typedef enum logic [0:0] {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     s_q, s_d;
  logic [W-1:0]   sh0_q, sh0_d;
  logic [W-1:0]   sh1_q, sh1_d;
  logic [W-1:0]   sh2_q, sh2_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   c_q, c_d;
  logic [W-1:0]   d_q, d_d;
  logic           fv_q, fv_d;
  logic           se_q, se_d;

  // State, slot counter, shadow and frame registers; async clear drops any partial frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_HUNT;
      s_q     <= 2'd0;
      sh0_q   <= '0;
      sh1_q   <= '0;
      sh2_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      fv_q    <= 1'b0;
      se_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      sh0_q   <= sh0_d;
      sh1_q   <= sh1_d;
      sh2_q   <= sh2_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
      fv_q    <= fv_d;
      se_q    <= se_d;
    end
  end

  // Framing FSM: slot tracking, sample capture and frame publication per strobe
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    sh0_d   = sh0_q;
    sh1_d   = sh1_q;
    sh2_d   = sh2_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    d_d     = d_q;
    fv_d    = 1'b0;
    se_d    = 1'b0;
    if (en) begin
      case (state_q)
        ST_HUNT: begin
          // Samples before the first sync are simply ignored
          if (sync) begin
            sh0_d   = din;
            s_d     = 2'd1;
            state_d = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (sync) begin
            // A sync mid-frame abandons the partial frame and restarts at slot 0
            if (s_q != 2'd0) se_d = 1'b1;
            sh0_d = din;
            s_d   = 2'd1;
          end else begin
            case (s_q)
              2'd0: begin
                // Expected a sync here: lock is lost
                se_d    = 1'b1;
                s_d     = 2'd0;
                state_d = ST_HUNT;
              end
              2'd1: begin
                sh1_d = din;
                s_d   = 2'd2;
              end
              2'd2: begin
                sh2_d = din;
                s_d   = 2'd3;
              end
              default: begin
                // Slot 3 goes straight to d so the frame appears one clock after its last sample
                a_d  = sh0_q;
                b_d  = sh1_q;
                c_d  = sh2_q;
                d_d  = din;
                fv_d = 1'b1;
                s_d  = 2'd0;
              end
            endcase
          end
        end
        default: begin
          state_d = ST_HUNT;
          s_d     = 2'd0;
        end
      endcase
    end
  end

`ifdef TDM_ERR_CNT_EN
  logic [7:0] errcnt_q;

  // Saturating count of framing violations, advanced together with each sync_err pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      errcnt_q <= 8'd0;
    end else if (se_d && (errcnt_q != 8'hFF)) begin
      errcnt_q <= errcnt_q + 8'd1;
    end
  end

  assign err_cnt = errcnt_q;
`endif

  assign a           = a_q;
  assign b           = b_q;
  assign c           = c_q;
  assign d           = d_q;
  assign S           = s_q;
  assign frame_valid = fv_q;
  assign sync_err    = se_q;

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux4.sv
`default_nettype none
// ============================================================================
// Module      : tb_tdm_demux4
// Description : Self-checking bench for tdm_demux4. Directed scenarios plus
//               random strobes, compared against a queue-based frame model.
//               Optional feature macro: TDM_ERR_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tdm_demux4;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         sync;
  logic [W-1:0] din;
  logic [W-1:0] a, b, c, d;
  logic [1:0]   S;
  logic         frame_valid;
  logic         sync_err;
`ifdef TDM_ERR_CNT_EN
  logic [7:0]   err_cnt;
`endif

  tdm_demux4 #(.W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .sync        (sync),
    .din         (din),
    .a           (a),
    .b           (b),
    .c           (c),
    .d           (d),
    .S           (S),
`ifdef TDM_ERR_CNT_EN
    .err_cnt     (err_cnt),
`endif
    .frame_valid (frame_valid),
    .sync_err    (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: the frame under construction is a queue of samples
  logic [W-1:0] fq[$];
  bit           m_locked;
  logic [W-1:0] exp_a, exp_b, exp_c, exp_d;
  logic         exp_fv, exp_se;
  int           m_err;

  task automatic model_reset();
    fq.delete();
    m_locked = 1'b0;
    exp_a = '0; exp_b = '0; exp_c = '0; exp_d = '0;
    exp_fv = 1'b0; exp_se = 1'b0;
    m_err = 0;
  endtask

  task automatic model_strobe(input logic e, input logic s, input logic [W-1:0] dv);
    exp_fv = 1'b0;
    exp_se = 1'b0;
    if (e) begin
      if (s) begin
        if (m_locked && fq.size() != 0) exp_se = 1'b1;
        fq.delete();
        fq.push_back(dv);
        m_locked = 1'b1;
      end else if (m_locked) begin
        if (fq.size() == 0) begin
          exp_se   = 1'b1;
          m_locked = 1'b0;
        end else begin
          fq.push_back(dv);
          if (fq.size() == 4) begin
            exp_a  = fq[0];
            exp_b  = fq[1];
            exp_c  = fq[2];
            exp_d  = fq[3];
            exp_fv = 1'b1;
            fq.delete();
          end
        end
      end
    end
    if (exp_se && m_err < 255) m_err++;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("a", 32'(a), 32'(exp_a));
    chk("b", 32'(b), 32'(exp_b));
    chk("c", 32'(c), 32'(exp_c));
    chk("d", 32'(d), 32'(exp_d));
    chk("S", 32'(S), 32'(fq.size()));
    chk("frame_valid", 32'(frame_valid), 32'(exp_fv));
    chk("sync_err", 32'(sync_err), 32'(exp_se));
`ifdef TDM_ERR_CNT_EN
    chk("err_cnt", 32'(err_cnt), 32'(m_err));
`endif
  endtask

  // Drive one cycle of inputs, let the edge happen, then check everything
  task automatic step(input logic e, input logic s, input logic [W-1:0] dv);
    en = e; sync = s; din = dv;
    @(posedge clk);
    model_strobe(e, s, dv);
    #1;
    check_all();
  endtask

  logic [W-1:0] vals [4];
  logic [W-1:0] early;
  int           tcnt;
  logic         rs;

  initial begin
    rst_n = 1'b0; en = 1'b0; sync = 1'b0; din = '0;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Hunt: strobes without sync are ignored
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, W'(4'hF));
    chk("hunt_S", 32'(S), 32'd0);

    // Nominal frame 1,0,1,1
    step(1'b1, 1'b1, W'(1));
    step(1'b1, 1'b0, W'(0));
    step(1'b1, 1'b0, W'(1));
    step(1'b1, 1'b0, W'(1));
    chk("nom_a", 32'(a), 32'd1);
    chk("nom_b", 32'(b), 32'd0);
    chk("nom_c", 32'(c), 32'd1);
    chk("nom_d", 32'(d), 32'd1);
    chk("nom_fv", 32'(frame_valid), 32'd1);
    step(1'b0, 1'b0, W'(0));
    chk("nom_fv_pulse", 32'(frame_valid), 32'd0);

    // Early sync at S=2: partial frame dropped, new frame starts at the sync sample
    step(1'b1, 1'b1, W'(4'h3));
    step(1'b1, 1'b0, W'(4'h4));
    early = W'(4'h9);
    step(1'b1, 1'b1, early);
    chk("early_se", 32'(sync_err), 32'd1);
    chk("early_S", 32'(S), 32'd1);
    chk("early_a_hold", 32'(a), 32'd1);
    step(1'b1, 1'b0, W'(4'hA));
    chk("early_se_pulse", 32'(sync_err), 32'd0);
    step(1'b1, 1'b0, W'(4'hB));
    step(1'b1, 1'b0, W'(4'hC));
    chk("early_frame_a", 32'(a), 32'(early));
    chk("early_frame_d", 32'(d), 32'hC);

    // Missing sync at slot 0 drops lock; a following sync re-locks
    step(1'b1, 1'b0, W'(4'h5));
    chk("miss_se", 32'(sync_err), 32'd1);
    step(1'b1, 1'b0, W'(4'h6));
    chk("miss_hunt_quiet", 32'(sync_err), 32'd0);
    step(1'b1, 1'b1, W'(4'h7));
    chk("relock_S", 32'(S), 32'd1);

    // Asynchronous reset mid-frame
    step(1'b1, 1'b0, W'(4'h8));
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_a", 32'(a), 32'd0);
    chk("rst_S", 32'(S), 32'd0);
    chk("rst_fv", 32'(frame_valid), 32'd0);
    chk("rst_se", 32'(sync_err), 32'd0);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Stall and loopback: din is chosen by the DUT's own slot select
    for (int i = 0; i < 4; i++) vals[i] = W'($urandom);
    for (int k = 0; k < 8; k++) begin
      step((k % 2) == 0, ((k % 2) == 0) && (S == 2'd0) && (k == 0), vals[S]);
    end
    chk("loop_a", 32'(a), 32'(vals[0]));
    chk("loop_b", 32'(b), 32'(vals[1]));
    chk("loop_c", 32'(c), 32'(vals[2]));
    chk("loop_d", 32'(d), 32'(vals[3]));

    // Back-to-back frames with random stalls and occasional framing faults
    tcnt = 0;
    for (int i = 0; i < 300; i++) begin
      logic e;
      e  = ($urandom_range(0, 3) != 0);
      rs = (tcnt == 0) ^ ($urandom_range(0, 11) == 0);
      step(e, rs, W'($urandom));
      if (e) tcnt = (tcnt + 1) % 4;
    end

`ifdef TDM_ERR_CNT_EN
    // Drive the error counter into saturation: every sync after the first is a violation
    for (int i = 0; i < 301; i++) step(1'b1, 1'b1, W'($urandom));
    chk("err_cnt_sat", 32'(err_cnt), 32'hFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
